// File: rtl/shift_reg_arbiter_if.sv
// -----------------------------------------------------------------------------
// shift_reg_arbiter_if
//
// Bundles the requester handshake and the serial output of shift_reg_arbiter.
//
//   req0 / req1     requester has a word pending (held until its gnt is seen)
//   data0 / data1   requester words, stable while the matching req is high
//   gnt0 / gnt1     one-cycle pulse: the matching word has been captured
//   ser_out         serial bit, LSB first, 0 whenever ser_valid is low
//   ser_valid       ser_out carries a valid bit
//   busy            sequencer is not idle
//   done            one-cycle pulse after the last bit of a word
//
// Modports:
//   master  requester / link side (drives req and data, observes the rest)
//   slave   the arbiter itself
// -----------------------------------------------------------------------------
interface shift_reg_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    modport master (
        output req0, data0, req1, data1,
        input  gnt0, gnt1, ser_out, ser_valid, busy, done
    );

    modport slave (
        input  req0, data0, req1, data1,
        output gnt0, gnt1, ser_out, ser_valid, busy, done
    );
endinterface

// File: rtl/shift_reg_arbiter.sv
// -----------------------------------------------------------------------------
// shift_reg_arbiter
//
// Shares one WIDTH-bit right-shift register between two parallel requesters.
// A granted word is loaded into the register and shifted out LSB first on
// ser_out for WIDTH consecutive cycles, followed by a one-cycle done pulse and
// a return to idle. When both requesters are pending in idle, the one that was
// not granted last wins (round-robin); requester 0 wins the first tie after
// reset.
//
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous, active-high reset (aborts any word in flight)
//   bus     shift_reg_arbiter_if.slave: req0/data0, req1/data1 in;
//           gnt0, gnt1, ser_out, ser_valid, busy, done out
//
// WIDTH: word length, 2..16.
// -----------------------------------------------------------------------------
module shift_reg_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    shift_reg_arbiter_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] shreg_next;
    logic [CW-1:0]    cnt_reg;
    logic             last_reg;
    logic             gnt0_reg;
    logic             gnt1_reg;
    logic             any_req;
    logic             win1;

    // Right shift with zero fill: each bit takes its upper neighbour.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_top
                assign shreg_next[gi] = 1'b0;
            end else begin : g_low
                assign shreg_next[gi] = shreg_reg[gi + 1];
            end
        end
    endgenerate

    // Requester 1 wins when it is alone, or on a tie when requester 0 was the
    // previous winner (last_reg == 0).
    assign any_req = bus.req0 | bus.req1;
    assign win1    = bus.req1 & (~bus.req0 | ~last_reg);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
            last_reg  <= 1'b1;
            gnt0_reg  <= 1'b0;
            gnt1_reg  <= 1'b0;
        end else begin
            // Grants are single-cycle: cleared on every edge unless re-set below.
            gnt0_reg <= 1'b0;
            gnt1_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        shreg_reg <= win1 ? bus.data1 : bus.data0;
                        cnt_reg   <= '0;
                        gnt0_reg  <= ~win1;
                        gnt1_reg  <= win1;
                        last_reg  <= win1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_reg <= shreg_next;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0      = gnt0_reg;
    assign bus.gnt1      = gnt1_reg;
    assign bus.ser_valid = (state_reg == SHIFT);
    assign bus.ser_out   = (state_reg == SHIFT) ? shreg_reg[0] : 1'b0;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = (state_reg == DONE);
endmodule

// File: tb/tb_shift_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_arbiter
//
// Drives shift_reg_arbiter (WIDTH=4) with directed request sequences. A
// timeline model predicts every output each cycle; a log of observed grants,
// serial bits, done and busy cycles is compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_shift_reg_arbiter;
    localparam int W = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    shift_reg_arbiter_if #(.WIDTH(W)) bus ();

    shift_reg_arbiter #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Model: mdl_pos is the position inside the word timeline.
    //   -1      idle
    //   0..W-1  bit mdl_pos of mdl_word is on the serial line
    //   W       done cycle
    // ------------------------------------------------------------------
    int         mdl_pos  = -1;
    int         mdl_last = 1;
    int         mdl_win  = 0;
    logic [W-1:0] mdl_word = '0;
    int         mdl_gnt0 = 0;
    int         mdl_gnt1 = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mdl_pos  = -1;
            mdl_last = 1;
            mdl_gnt0 = 0;
            mdl_gnt1 = 0;
        end else begin
            mdl_gnt0 = 0;
            mdl_gnt1 = 0;
            if (mdl_pos < 0) begin
                if (bus.req0 || bus.req1) begin
                    if (bus.req0 && bus.req1) mdl_win = 1 - mdl_last;
                    else if (bus.req1)        mdl_win = 1;
                    else                      mdl_win = 0;
                    mdl_word = (mdl_win == 1) ? bus.data1 : bus.data0;
                    if (mdl_win == 1) mdl_gnt1 = 1;
                    else              mdl_gnt0 = 1;
                    mdl_last = mdl_win;
                    mdl_pos  = 0;
                end
            end else if (mdl_pos == W) begin
                mdl_pos = -1;
            end else begin
                mdl_pos = mdl_pos + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare plus observation log.
    // ------------------------------------------------------------------
    int cyc = 0;
    int gnt_who[$];
    int gnt_cyc[$];
    bit bits[$];
    int done_cnt = 0;
    int busy_cnt = 0;

    always @(negedge clock) begin
        int exp_valid;
        int exp_out;
        cyc++;
        exp_valid = (mdl_pos >= 0 && mdl_pos < W) ? 1 : 0;
        exp_out   = 0;
        if (exp_valid == 1) exp_out = int'(mdl_word[mdl_pos]);
        check("cyc_gnt0",      int'(bus.gnt0),      mdl_gnt0);
        check("cyc_gnt1",      int'(bus.gnt1),      mdl_gnt1);
        check("cyc_ser_valid", int'(bus.ser_valid), exp_valid);
        check("cyc_ser_out",   int'(bus.ser_out),   exp_out);
        check("cyc_busy",      int'(bus.busy),      (mdl_pos >= 0) ? 1 : 0);
        check("cyc_done",      int'(bus.done),      (mdl_pos == W) ? 1 : 0);
        if (bus.gnt0) begin
            gnt_who.push_back(0);
            gnt_cyc.push_back(cyc);
            $display("cycle %0d: grant requester 0, data 0x%0h", cyc, bus.data0);
        end
        if (bus.gnt1) begin
            gnt_who.push_back(1);
            gnt_cyc.push_back(cyc);
            $display("cycle %0d: grant requester 1, data 0x%0h", cyc, bus.data1);
        end
        if (bus.ser_valid) bits.push_back(bus.ser_out);
        if (bus.done) begin
            done_cnt++;
            $display("cycle %0d: word done", cyc);
        end
        if (bus.busy) busy_cnt++;
    end

    // ------------------------------------------------------------------
    // Requester engine: each queue holds words still to be offered. A req
    // drops in the cycle its gnt is seen and is re-raised with the next word
    // one cycle later.
    // ------------------------------------------------------------------
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    task automatic step();
        @(negedge clock);
        #1;
        if (bus.gnt0) bus.req0 = 1'b0;
        else if (!bus.req0 && q0.size() > 0) begin
            bus.data0 = q0.pop_front();
            bus.req0  = 1'b1;
        end
        if (bus.gnt1) bus.req1 = 1'b0;
        else if (!bus.req1 && q1.size() > 0) begin
            bus.data1 = q1.pop_front();
            bus.req1  = 1'b1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        gnt_who.delete();
        gnt_cyc.delete();
        bits.delete();
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    function automatic int packed_bits();
        int v = 0;
        for (int i = 0; i < bits.size() && i < 31; i++) v = v | (int'(bits[i]) << i);
        return v;
    endfunction

    function automatic int who(input int i);
        return (i < gnt_who.size()) ? gnt_who[i] : -1;
    endfunction

    function automatic int gap(input int i);
        return (i + 1 < gnt_cyc.size()) ? gnt_cyc[i + 1] - gnt_cyc[i] : -1;
    endfunction

    task automatic reset_pulse();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int waited;
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.data0 = '0;
        bus.data1 = '0;

        // Reset asserted between clock edges: outputs are 0 straight away.
        #1;
        reset = 1'b1;
        #1;
        check("reset_ser_valid", int'(bus.ser_valid), 0);
        check("reset_ser_out",   int'(bus.ser_out),   0);
        check("reset_busy",      int'(bus.busy),      0);
        check("reset_done",      int'(bus.done),      0);
        check("reset_gnt",       int'(bus.gnt0) + int'(bus.gnt1), 0);
        run(3);
        reset = 1'b0;
        clear_log();
        run(10);
        check("idle_busy_cycles", busy_cnt, 0);
        check("idle_grants", gnt_who.size(), 0);

        // Single word 1011: bits 1,1,0,1; SHIFT(4)+DONE(1) = 5 busy cycles.
        clear_log();
        q0.push_back(4'b1011);
        run(12);
        check("single_grant_count", gnt_who.size(), 1);
        check("single_grant_who",   who(0), 0);
        check("single_bit_count",   bits.size(), 4);
        check("single_bits",        packed_bits(), 4'b1011);
        check("single_done_count",  done_cnt, 1);
        check("single_busy_cycles", busy_cnt, 5);

        // Tie after reset: 0 first (bits 1,0,1,0), then 1 (bits 0,1,0,1).
        reset_pulse();
        clear_log();
        q0.push_back(4'h5);
        q1.push_back(4'hA);
        run(20);
        check("tie_grant_count", gnt_who.size(), 2);
        check("tie_first",       who(0), 0);
        check("tie_second",      who(1), 1);
        check("tie_gap",         gap(0), 6);
        check("tie_bits",        packed_bits(), 8'hA5);
        check("tie_done_count",  done_cnt, 2);

        // Fairness: both requesters keep three words each pending.
        clear_log();
        q0.push_back(4'h1); q0.push_back(4'h2); q0.push_back(4'h3);
        q1.push_back(4'hC); q1.push_back(4'hD); q1.push_back(4'hE);
        run(50);
        check("rr_grant_count", gnt_who.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("rr_who_%0d", i), who(i), i % 2);
        for (int i = 0; i < 5; i++) check($sformatf("rr_gap_%0d", i), gap(i), 6);
        check("rr_done_count", done_cnt, 6);

        // Request raised during SHIFT waits until the FSM is idle again.
        clear_log();
        q0.push_back(4'h9);
        waited = 0;
        while (gnt_who.size() == 0 && waited < 10) begin
            step();
            waited++;
        end
        check("shreq_gnt0_seen", gnt_who.size(), 1);
        q1.push_back(4'h6);
        step();
        run(15);
        check("shreq_grant_count", gnt_who.size(), 2);
        check("shreq_second_who",  who(1), 1);
        check("shreq_gap",         gap(0), 6);
        check("shreq_bits",        packed_bits(), 8'h69);

        // Reset on the third serial bit of a requester-0 word.
        clear_log();
        q0.push_back(4'hE);
        waited = 0;
        while (bits.size() < 3 && waited < 12) begin
            step();
            waited++;
        end
        check("midrst_bits_before", bits.size(), 3);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_ser_valid", int'(bus.ser_valid), 0);
        check("midrst_ser_out",   int'(bus.ser_out),   0);
        check("midrst_busy",      int'(bus.busy),      0);
        check("midrst_done",      int'(bus.done),      0);
        step();
        reset = 1'b0;
        run(6);
        check("midrst_no_done", done_cnt, 0);
        // last was 0 before reset; reset restores 1, so requester 0 wins the tie.
        clear_log();
        q0.push_back(4'h3);
        q1.push_back(4'h6);
        run(20);
        check("midrst_tie_first",  who(0), 0);
        check("midrst_tie_second", who(1), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
